// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared constants and types for the unified-memory port arbiter.
// Holds the FSM state encoding, the requester id encoding, default bus
// widths and a small helper used to size saturating counters.
package mem_port_arbiter_pkg;

  localparam int DEFAULT_DATA_W     = 19;
  localparam int DEFAULT_ADDR_W     = 19;
  localparam int DEFAULT_MEM_LAT    = 1;
  localparam int DEFAULT_STARVE_MAX = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_DM = 1'b1
  } req_id_t;

  // Number of bits needed to hold values 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << w) <= max_val) w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr
// Saturating count of consecutive DM grants made while IF was waiting.
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   dm_grant   DM wins arbitration this cycle
//   if_pending IF request is high this cycle
//   if_grant   IF wins arbitration this cycle
//   at_max     count has reached STARVE_MAX; IF must win the next contest
module arb_starve_ctr
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = DEFAULT_STARVE_MAX
) (
  input  logic clk,
  input  logic reset,
  input  logic dm_grant,
  input  logic if_pending,
  input  logic if_grant,
  output logic at_max
);

  localparam int CW = cnt_width(STARVE_MAX);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_MAX);

  logic [CW-1:0] count;

  // A DM grant with no IF waiting breaks the run of starving grants, so it
  // clears the count just like an IF grant does.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (if_grant) begin
      count <= '0;
    end else if (dm_grant) begin
      if (!if_pending) begin
        count <= '0;
      end else if (count != LIMIT) begin
        count <= count + 1'b1;
      end
    end
  end

  assign at_max = (count == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported memory between instruction fetch (IF, read only)
// and data access (DM, load/store). One transaction in flight at a time,
// fixed read latency MEM_LAT. DM has priority; after STARVE_MAX consecutive
// DM wins against a waiting IF, IF gets the next grant.
// Ports:
//   CLK, RESET                       clock, synchronous active-high reset
//   IF_REQ/IF_ADDR                   fetch request and address
//   IF_GNT/IF_DONE/IF_RDATA          fetch issued, fetch data valid, data
//   DM_REQ/DM_WE/DM_ADDR/DM_WDATA    data request, store flag, addr, data
//   DM_GNT/DM_DONE/DM_RDATA          access issued, access complete, data
//   MEM_EN/MEM_WE/MEM_ADDR/MEM_WDATA memory command (valid in ISSUE only)
//   MEM_RDATA                        memory read data
//   BUSY                             a transaction is in flight
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int ADDR_W     = DEFAULT_ADDR_W,
  parameter int MEM_LAT    = DEFAULT_MEM_LAT,
  parameter int STARVE_MAX = DEFAULT_STARVE_MAX
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              IF_REQ,
  input  logic [ADDR_W-1:0] IF_ADDR,
  output logic              IF_GNT,
  output logic              IF_DONE,
  output logic [DATA_W-1:0] IF_RDATA,
  input  logic              DM_REQ,
  input  logic              DM_WE,
  input  logic [ADDR_W-1:0] DM_ADDR,
  input  logic [DATA_W-1:0] DM_WDATA,
  output logic              DM_GNT,
  output logic              DM_DONE,
  output logic [DATA_W-1:0] DM_RDATA,
  output logic              MEM_EN,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic              BUSY
);

  localparam int WCW = cnt_width(MEM_LAT);
  // WAIT lasts MEM_LAT-1 cycles; the counter is loaded with one less than
  // that so it reaches zero in the last WAIT cycle.
  localparam logic [WCW-1:0] WAIT_LOAD = WCW'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);

  arb_state_t     state;
  req_id_t        owner;
  logic           is_store;
  logic [WCW-1:0] wait_cnt;

  logic dm_win;
  logic if_win;
  logic at_max;
  logic go_done;

  arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk        (CLK),
    .reset      (RESET),
    .dm_grant   (dm_win),
    .if_pending (IF_REQ),
    .if_grant   (if_win),
    .at_max     (at_max)
  );

  // Arbitration only happens in IDLE. DM wins unless IF is also waiting
  // and has already been passed over STARVE_MAX times in a row.
  always_comb begin
    dm_win = 1'b0;
    if_win = 1'b0;
    if (state == IDLE) begin
      if (DM_REQ && !(IF_REQ && at_max)) begin
        dm_win = 1'b1;
      end else if (IF_REQ) begin
        if_win = 1'b1;
      end
    end
  end

  // Stores, and reads with single-cycle latency, finish straight from ISSUE;
  // longer reads finish when the WAIT counter runs out.
  always_comb begin
    go_done = 1'b0;
    case (state)
      ISSUE:   go_done = is_store || (MEM_LAT <= 1);
      WAIT:    go_done = (wait_cnt == '0);
      default: go_done = 1'b0;
    endcase
  end

  // Single FSM with every output registered. The MEM_* registers double as
  // the latch for the winner's command: they are loaded on the grant edge
  // and cleared again on the following edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      owner     <= REQ_IF;
      is_store  <= 1'b0;
      wait_cnt  <= '0;
      IF_GNT    <= 1'b0;
      IF_DONE   <= 1'b0;
      IF_RDATA  <= '0;
      DM_GNT    <= 1'b0;
      DM_DONE   <= 1'b0;
      DM_RDATA  <= '0;
      MEM_EN    <= 1'b0;
      MEM_WE    <= 1'b0;
      MEM_ADDR  <= '0;
      MEM_WDATA <= '0;
      BUSY      <= 1'b0;
    end else begin
      IF_GNT    <= 1'b0;
      DM_GNT    <= 1'b0;
      IF_DONE   <= 1'b0;
      DM_DONE   <= 1'b0;
      MEM_EN    <= 1'b0;
      MEM_WE    <= 1'b0;
      MEM_ADDR  <= '0;
      MEM_WDATA <= '0;

      case (state)
        IDLE: begin
          if (dm_win || if_win) begin
            owner     <= dm_win ? REQ_DM : REQ_IF;
            is_store  <= dm_win && DM_WE;
            MEM_EN    <= 1'b1;
            MEM_WE    <= dm_win && DM_WE;
            MEM_ADDR  <= dm_win ? DM_ADDR : IF_ADDR;
            MEM_WDATA <= (dm_win && DM_WE) ? DM_WDATA : '0;
            IF_GNT    <= if_win;
            DM_GNT    <= dm_win;
            BUSY      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (!go_done) begin
            wait_cnt <= WAIT_LOAD;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (!go_done) begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        DONE: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      // MEM_RDATA is valid exactly at the edge that enters DONE, so the
      // owner's read-data register is loaded here and then held.
      if (go_done) begin
        state   <= DONE;
        IF_DONE <= (owner == REQ_IF);
        DM_DONE <= (owner == REQ_DM);
        if (!is_store) begin
          if (owner == REQ_IF) begin
            IF_RDATA <= MEM_RDATA;
          end else begin
            DM_RDATA <= MEM_RDATA;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Scoreboard bench: each driven request pushes its expected transaction;
// a negedge monitor pops on grant and checks command, latency, read data,
// BUSY and the idle behaviour of every output.
module tb_mem_port_arbiter;

  localparam int LAT    = 3;
  localparam int STARVE = 3;

  logic        CLK;
  logic        RESET;
  logic        IF_REQ;
  logic [18:0] IF_ADDR;
  logic        IF_GNT;
  logic        IF_DONE;
  logic [18:0] IF_RDATA;
  logic        DM_REQ;
  logic        DM_WE;
  logic [18:0] DM_ADDR;
  logic [18:0] DM_WDATA;
  logic        DM_GNT;
  logic        DM_DONE;
  logic [18:0] DM_RDATA;
  logic        MEM_EN;
  logic        MEM_WE;
  logic [18:0] MEM_ADDR;
  logic [18:0] MEM_WDATA;
  logic [18:0] MEM_RDATA;
  logic        BUSY;

  mem_port_arbiter #(
    .DATA_W     (19),
    .ADDR_W     (19),
    .MEM_LAT    (LAT),
    .STARVE_MAX (STARVE)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .IF_REQ    (IF_REQ),
    .IF_ADDR   (IF_ADDR),
    .IF_GNT    (IF_GNT),
    .IF_DONE   (IF_DONE),
    .IF_RDATA  (IF_RDATA),
    .DM_REQ    (DM_REQ),
    .DM_WE     (DM_WE),
    .DM_ADDR   (DM_ADDR),
    .DM_WDATA  (DM_WDATA),
    .DM_GNT    (DM_GNT),
    .DM_DONE   (DM_DONE),
    .DM_RDATA  (DM_RDATA),
    .MEM_EN    (MEM_EN),
    .MEM_WE    (MEM_WE),
    .MEM_ADDR  (MEM_ADDR),
    .MEM_WDATA (MEM_WDATA),
    .MEM_RDATA (MEM_RDATA),
    .BUSY      (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    bit          is_dm;
    bit          we;
    logic [18:0] addr;
    logic [18:0] wdata;
    logic [18:0] rdata;
  } txn_t;

  txn_t        exp_q[$];
  txn_t        cur;
  bit          in_flight = 1'b0;
  int          cycle = 0;
  int          gnt_cycle = 0;
  int          last_done_cycle = -10;
  logic [18:0] if_rd_exp = '0;
  logic [18:0] dm_rd_exp = '0;
  bit          mon_en = 1'b0;
  bit          rst_at_edge = 1'b0;
  int          errors = 0;
  int          checks = 0;

  logic [18:0] bench_mem [int];
  logic [18:0] ref_mem [int];
  int          rd_cd = -1;
  logic [18:0] rd_val = '0;

  function automatic logic [18:0] fillWord(input logic [18:0] a);
    return a ^ 19'h2AAAA;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  // Memory macro model: data for a read is presented only in the window
  // where the arbiter should sample it, random values otherwise.
  always @(negedge CLK) begin
    if (MEM_EN === 1'b1 && MEM_WE === 1'b1) begin
      bench_mem[int'(MEM_ADDR)] = MEM_WDATA;
    end
    if (MEM_EN === 1'b1 && MEM_WE === 1'b0) begin
      rd_val = bench_mem.exists(int'(MEM_ADDR)) ? bench_mem[int'(MEM_ADDR)] : fillWord(MEM_ADDR);
      rd_cd  = LAT - 1;
    end else if (rd_cd > 0) begin
      rd_cd--;
    end else begin
      rd_cd = -1;
    end
    if (rd_cd == 0) MEM_RDATA = rd_val;
    else            MEM_RDATA = 19'($urandom);
  end

  always @(posedge CLK) begin
    rst_at_edge = RESET;
    mon_en      = 1'b1;
  end

  // Monitor: pops the expectation on grant, checks completion on done.
  always @(negedge CLK) begin
    if (mon_en) begin
      cycle++;
      if (rst_at_edge) begin
        in_flight       = 1'b0;
        if_rd_exp       = '0;
        dm_rd_exp       = '0;
        last_done_cycle = -10;
      end
      checkOutput("gnt_onehot", 32'(IF_GNT & DM_GNT), 32'd0);
      checkOutput("mem_en", 32'(MEM_EN), 32'(IF_GNT | DM_GNT));
      if (IF_GNT | DM_GNT) begin
        if (exp_q.size() == 0 || in_flight) begin
          checkOutput("unexpected_gnt", 32'd1, 32'd0);
        end else begin
          cur = exp_q.pop_front();
          checkOutput("gnt_id", 32'({IF_GNT, DM_GNT}), cur.is_dm ? 32'd1 : 32'd2);
          checkOutput("mem_we", 32'(MEM_WE), 32'(cur.we));
          checkOutput("mem_addr", 32'(MEM_ADDR), 32'(cur.addr));
          checkOutput("mem_wdata", 32'(MEM_WDATA), cur.we ? 32'(cur.wdata) : 32'd0);
          checkOutput("idle_gap", 32'(cycle - last_done_cycle >= 2), 32'd1);
          gnt_cycle = cycle;
          in_flight = 1'b1;
        end
      end else begin
        checkOutput("mem_we_idle", 32'(MEM_WE), 32'd0);
        checkOutput("mem_addr_idle", 32'(MEM_ADDR), 32'd0);
        checkOutput("mem_wdata_idle", 32'(MEM_WDATA), 32'd0);
      end
      checkOutput("busy", 32'(BUSY), 32'(in_flight));
      if (IF_DONE | DM_DONE) begin
        checkOutput("done_onehot", 32'(IF_DONE & DM_DONE), 32'd0);
        if (!in_flight) begin
          checkOutput("unexpected_done", 32'd1, 32'd0);
        end else begin
          checkOutput("done_id", 32'({IF_DONE, DM_DONE}), cur.is_dm ? 32'd1 : 32'd2);
          checkOutput("latency", 32'(cycle - gnt_cycle), cur.we ? 32'd1 : 32'(LAT));
          if (!cur.we) begin
            if (cur.is_dm) dm_rd_exp = cur.rdata;
            else           if_rd_exp = cur.rdata;
          end
          last_done_cycle = cycle;
          in_flight       = 1'b0;
        end
      end
      checkOutput("if_rdata", 32'(IF_RDATA), 32'(if_rd_exp));
      checkOutput("dm_rdata", 32'(DM_RDATA), 32'(dm_rd_exp));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pushExp(input bit is_dm, input bit we, input logic [18:0] addr,
                         input logic [18:0] wdata);
    txn_t t;
    t.is_dm = is_dm;
    t.we    = we;
    t.addr  = addr;
    t.wdata = wdata;
    t.rdata = '0;
    if (we) ref_mem[int'(addr)] = wdata;
    else    t.rdata = ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : fillWord(addr);
    exp_q.push_back(t);
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || in_flight) && n < 30) begin
      tick();
      n++;
    end
    checkOutput("done_timeout", 32'(exp_q.size() == 0 && !in_flight), 32'd1);
    tick();
  endtask

  task automatic waitGrant(input bit is_dm);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (is_dm ? DM_GNT : IF_GNT) got = 1'b1;
    end
    checkOutput("gnt_timeout", 32'(got), 32'd1);
  endtask

  // One standalone transaction from one requester.
  task automatic applyStimulus(input bit is_dm, input bit we, input logic [18:0] addr,
                               input logic [18:0] wdata);
    pushExp(is_dm, we, addr, wdata);
    if (is_dm) begin
      DM_REQ = 1'b1; DM_WE = we; DM_ADDR = addr; DM_WDATA = wdata;
    end else begin
      IF_REQ = 1'b1; IF_ADDR = addr;
    end
    waitGrant(is_dm);
    DM_REQ = 1'b0;
    IF_REQ = 1'b0;
    waitIdle();
  endtask

  initial begin
    int n_if;
    int n_dm;
    int guard;
    RESET = 1'b1;
    IF_REQ = 1'b0; IF_ADDR = '0;
    DM_REQ = 1'b0; DM_WE = 1'b0; DM_ADDR = '0; DM_WDATA = '0;
    MEM_RDATA = '0;
    bench_mem[32'h10] = 19'h5A5A5;
    ref_mem[32'h10]   = 19'h5A5A5;
    repeat (3) tick();
    RESET = 1'b0;
    tick();

    applyStimulus(1'b0, 1'b0, 19'h00010, '0);
    applyStimulus(1'b1, 1'b1, 19'h00100, 19'h7FFFF);
    applyStimulus(1'b1, 1'b0, 19'h00100, '0);
    applyStimulus(1'b1, 1'b0, 19'h00020, '0);
    applyStimulus(1'b0, 1'b0, 19'h00011, '0);

    // IF held high across two grants, address changed after the first.
    pushExp(1'b0, 1'b0, 19'h00050, '0);
    pushExp(1'b0, 1'b0, 19'h00060, '0);
    IF_REQ = 1'b1; IF_ADDR = 19'h00050;
    waitGrant(1'b0);
    IF_ADDR = 19'h00060;
    tick();
    waitGrant(1'b0);
    IF_REQ = 1'b0;
    waitIdle();

    // Reset during the WAIT state of an IF read aborts it.
    pushExp(1'b0, 1'b0, 19'h00070, '0);
    IF_REQ = 1'b1; IF_ADDR = 19'h00070;
    waitGrant(1'b0);
    IF_REQ = 1'b0;
    tick();
    RESET = 1'b1;
    exp_q.delete();
    tick();
    RESET = 1'b0;
    repeat (6) tick();

    // Build up starvation count, then reset mid-DM-read; afterwards the
    // contention pattern must start from a cleared count.
    pushExp(1'b1, 1'b0, 19'h00040, '0);
    pushExp(1'b1, 1'b0, 19'h00040, '0);
    IF_REQ = 1'b1; IF_ADDR = 19'h00030;
    DM_REQ = 1'b1; DM_WE = 1'b0; DM_ADDR = 19'h00040;
    n_dm = 0;
    guard = 0;
    while (n_dm < 2 && guard < 40) begin
      tick();
      if (DM_GNT) n_dm++;
      guard++;
    end
    checkOutput("pre_dm_grants", 32'(n_dm), 32'd2);
    tick();
    RESET = 1'b1;
    exp_q.delete();
    tick();
    for (int k = 0; k < 9; k++) begin
      pushExp((k == 3 || k == 7) ? 1'b0 : 1'b1, 1'b0,
              (k == 3 || k == 7) ? 19'h00030 : 19'h00040, '0);
    end
    RESET = 1'b0;
    n_if = 0;
    n_dm = 0;
    guard = 0;
    while (!(n_if == 2 && n_dm == 7 && exp_q.size() == 0 && !in_flight) && guard < 200) begin
      tick();
      if (IF_GNT) begin
        n_if++;
        if (n_if == 2) IF_REQ = 1'b0;
      end
      if (DM_GNT) begin
        n_dm++;
        if (n_dm == 7) DM_REQ = 1'b0;
      end
      guard++;
    end
    IF_REQ = 1'b0;
    DM_REQ = 1'b0;
    checkOutput("if_grants", 32'(n_if), 32'd2);
    checkOutput("dm_grants", 32'(n_dm), 32'd7);
    repeat (4) tick();
    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
